// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and packet formatter for the router bus terminals
//
// Purpose: common widths and codes, plus mk_pkt(), which builds a
// {dest, payload} word. mk_pkt works on a wide container so that any
// packet width up to PKT_MAX_W can use it. Callers cast the result
// down to their own packet width.
package router_pkg;

  localparam int         DEST_W    = 8;
  localparam logic [7:0] BROADCAST = 8'hFF;
  localparam int         CNT_W     = 16;
  localparam int         PKT_MAX_W = 128;

  // pay_w is the payload width. dest is placed directly above the payload,
  // and payload bits at or above pay_w are discarded.
  function automatic logic [PKT_MAX_W-1:0] mk_pkt(
    input logic [DEST_W-1:0]    dest,
    input logic [PKT_MAX_W-1:0] payload,
    input int                   pay_w
  );
    logic [PKT_MAX_W-1:0] mask;
    mask = (PKT_MAX_W'(1) << pay_w) - PKT_MAX_W'(1);
    return (PKT_MAX_W'(dest) << pay_w) | (payload & mask);
  endfunction

endpackage

// File: rtl/bus_tx_fifo.sv
// rtl/bus_tx_fifo.sv - generic show-ahead FIFO with a registered head word
//
// Purpose: a circular buffer whose head entry is always presented on rdata
// while the FIFO is not empty.
// Ports:
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   wr, wdata      - write strobe/data; ignored while full
//   rd             - retire the head entry; ignored while empty
//   rdata          - head entry; holds its last value when the FIFO is empty
//   empty, full    - registered from the next-count value
module bus_tx_fifo #(
  parameter int width = 32,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             rd,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_empty;
  logic             r_full;
  logic [width-1:0] r_rdata;

  logic             w_do_wr;
  logic             w_do_rd;
  logic [AW-1:0]    w_rd_ptr_n;
  logic [AW:0]      w_count_n;
  logic [width-1:0] w_rdata_n;

  // The full check uses the count before the edge, so a write while full
  // is dropped even if a read happens in the same cycle.
  assign w_do_wr = wr & ~r_full;
  assign w_do_rd = rd & ~r_empty;

  always_comb begin
    w_rd_ptr_n = r_rd_ptr + AW'(w_do_rd);
    w_count_n  = r_count + (AW+1)'(w_do_wr) - (AW+1)'(w_do_rd);
    w_rdata_n  = r_rdata;
    if (w_count_n != '0) begin
      // When the slot being written becomes the new head, the memory does
      // not hold it yet. Forward wdata straight into the head register.
      if (w_do_wr && (r_wr_ptr == w_rd_ptr_n))
        w_rdata_n = wdata;
      else
        w_rdata_n = r_mem[w_rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr)
      r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_do_wr);
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= w_count_n;
      r_empty  <= (w_count_n == '0);
      r_full   <= (w_count_n == (AW+1)'(depth));
      r_rdata  <= w_rdata_n;
    end
  end

  assign rdata = r_rdata;
  assign empty = r_empty;
  assign full  = r_full;

endmodule

// File: rtl/bus_terminal_tx.sv
// rtl/bus_terminal_tx.sv - transmit endpoint for one router_bus_gnrtr terminal
//
// Purpose: accepts host packets, filters self-addressed ones, buffers them
// in a show-ahead FIFO and presents the head packet to the router.
// Ports:
//   clk, reset                 - rising-edge clock, async active-high reset
//   push, push_dest, push_payload - host write side
//   full                       - FIFO holds fifo_depth entries
//   pndng_i_in, data_out_i_in  - head packet valid/data toward the router
//   popin                      - router retires the head packet
//   sent_cnt, drop_cnt         - saturating event counters
//   overflow, underflow        - sticky error flags
module bus_terminal_tx
  import router_pkg::*;
#(
  parameter int         pckg_sz    = 32,
  parameter int         fifo_depth = 16,
  parameter logic [7:0] term_id    = 8'd0,
  parameter logic [7:0] broadcast  = BROADCAST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [7:0]         push_dest,
  input  logic [pckg_sz-9:0] push_payload,
  output logic               full,
  output logic               pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic               popin,
  output logic [15:0]        sent_cnt,
  output logic [15:0]        drop_cnt,
  output logic               overflow,
  output logic               underflow
);

  logic [pckg_sz-1:0] w_pkt;
  logic               w_self;
  logic               w_accept;
  logic               w_drop;
  logic               w_retire;
  logic               w_empty;
  logic               w_full;

  logic [CNT_W-1:0]   r_sent_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_overflow;
  logic               r_underflow;

  assign w_pkt = pckg_sz'(mk_pkt(push_dest, PKT_MAX_W'(push_payload), pckg_sz - DEST_W));

  // Loopback is not supported. The broadcast code is always deliverable.
  assign w_self   = (push_dest == term_id) && (push_dest != broadcast);
  assign w_accept = push & ~w_full & ~w_self;
  assign w_drop   = push & ~w_accept;
  assign w_retire = popin & ~w_empty;

  bus_tx_fifo #(
    .width (pckg_sz),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (w_accept),
    .wdata (w_pkt),
    .rd    (w_retire),
    .rdata (data_out_i_in),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sent_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_retire && (r_sent_cnt != '1))
        r_sent_cnt <= r_sent_cnt + 1'b1;
      if (w_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 1'b1;
      if (push && w_full)
        r_overflow <= 1'b1;
      if (popin && w_empty)
        r_underflow <= 1'b1;
    end
  end

  assign full       = w_full;
  assign pndng_i_in = ~w_empty;
  assign sent_cnt   = r_sent_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule
